dmem_responder: RTL and testbench

//  Memory-side responder for the CPU data-memory port: accepts one load/store request per handshake,

---
 rtl/mem_pkg.sv | 19 +
 rtl/dmem_array.sv | 39 +++
 rtl/dmem_responder.sv | 116 +++++++++++
 tb/tb_dmem_responder.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared types and helpers for the data-memory responder.
package mem_pkg;

  localparam int unsigned WORD_W = 32;

  typedef enum logic [1:0] {
    StIdle,
    StWait,
    StResp
  } state_e;

  // Misaligned or beyond the last byte of a num_words-deep word store.
  function automatic logic addr_err(input logic [31:0] addr, input int unsigned num_words);
    logic [33:0] limit;
    limit = 34'(num_words) << 2;
    return (addr[1:0] != 2'b00) || ({2'b00, addr} >= limit);
  endfunction

endpackage

// File: rtl/dmem_array.sv
// Word-organised storage: synchronous write, registered read, synchronous active-low clear.
module dmem_array
  import mem_pkg::*;
#(
  parameter int unsigned NUM_WORDS = 16384,
  localparam int unsigned AW = $clog2(NUM_WORDS)
) (
  input  logic              clk,
  input  logic              clear_n,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [WORD_W-1:0] wdata,
  input  logic              re,
  input  logic [AW-1:0]     raddr,
  output logic [WORD_W-1:0] rdata
);

  logic [WORD_W-1:0] mem_q [NUM_WORDS];
  logic [WORD_W-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (!clear_n) begin
      for (int i = 0; i < int'(NUM_WORDS); i++) begin
        mem_q[i] <= '0;
      end
      rdata_q <= '0;
    end else begin
      if (we) begin
        mem_q[waddr] <= wdata;
      end
      if (re) begin
        rdata_q <= mem_q[raddr];
      end
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/dmem_responder.sv
// Memory-side responder for the CPU data port: one outstanding request, fixed access latency,
// response held until the CPU consumes it.
module dmem_responder
  import mem_pkg::*;
#(
  parameter int unsigned NUM_WORDS = 16384,
  parameter int unsigned LATENCY   = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [31:0]       req_addr,
  input  logic [WORD_W-1:0] req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [WORD_W-1:0] resp_rdata,
  output logic              resp_err
);

  localparam int unsigned AW      = $clog2(NUM_WORDS);
  localparam logic [3:0]  CntInit = 4'(LATENCY - 1);

  state_e            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              write_q, err_q;
  logic [AW-1:0]     idx_q;

  logic              accept;
  logic              enter_resp;
  logic              req_err;
  logic [AW-1:0]     req_idx;
  logic              is_load;
  logic              arr_re;
  logic [AW-1:0]     arr_raddr;
  logic [WORD_W-1:0] arr_rdata;

  assign req_err = addr_err(req_addr, NUM_WORDS);
  assign req_idx = req_addr[AW+1:2];
  assign accept  = (state_q == StIdle) && req_valid;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    enter_resp = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (req_valid) begin
          cnt_d = CntInit;
          if (LATENCY == 1) begin
            state_d    = StResp;
            enter_resp = 1'b1;
          end else begin
            state_d = StWait;
          end
        end
      end
      StWait: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d    = StResp;
          enter_resp = 1'b1;
        end
      end
      StResp: begin
        if (resp_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      write_q <= 1'b0;
      err_q   <= 1'b0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        write_q <= req_write;
        err_q   <= req_err;
        idx_q   <= req_idx;
      end
    end
  end

  // With single-cycle latency the read happens on the acceptance edge, before the latches load.
  assign is_load   = (state_q == StIdle) ? (!req_write && !req_err) : (!write_q && !err_q);
  assign arr_re    = enter_resp && is_load;
  assign arr_raddr = (state_q == StIdle) ? req_idx : idx_q;

  dmem_array #(
    .NUM_WORDS (NUM_WORDS)
  ) u_array (
    .clk     (clk),
    .clear_n (reset),
    .we      (accept && req_write && !req_err),
    .waddr   (req_idx),
    .wdata   (req_wdata),
    .re      (arr_re),
    .raddr   (arr_raddr),
    .rdata   (arr_rdata)
  );

  assign req_ready  = (state_q == StIdle);
  assign resp_valid = (state_q == StResp);
  assign resp_err   = resp_valid && err_q;
  assign resp_rdata = (resp_valid && !write_q && !err_q) ? arr_rdata : '0;

endmodule

// File: tb/tb_dmem_responder.sv
// Randomised and directed bench for dmem_responder against a transaction-level memory model.
module tb_dmem_responder;

  localparam int unsigned NW  = 16384;
  localparam int unsigned LAT = 2;

  logic        clk = 1'b0;
  logic        reset, req_valid, req_write, resp_ready;
  logic [31:0] req_addr, req_wdata;
  logic        req_ready, resp_valid, resp_err;
  logic [31:0] resp_rdata;

  always #5 clk = ~clk;

  dmem_responder #(.NUM_WORDS(NW), .LATENCY(LAT)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_write  (req_write),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err)
  );

  // Extreme-latency builds, streaming loads with the response side always ready.
  logic        side_reset;
  logic        s1_ready, s1_valid, s1_err, s15_ready, s15_valid, s15_err;
  logic [31:0] s1_rdata, s15_rdata;
  bit          side_done = 1'b0;

  dmem_responder #(.NUM_WORDS(1024), .LATENCY(1)) u_l1 (
    .clk        (clk),
    .reset      (side_reset),
    .req_valid  (1'b1),
    .req_ready  (s1_ready),
    .req_write  (1'b0),
    .req_addr   (32'h40),
    .req_wdata  (32'h0),
    .resp_valid (s1_valid),
    .resp_ready (1'b1),
    .resp_rdata (s1_rdata),
    .resp_err   (s1_err)
  );

  dmem_responder #(.NUM_WORDS(1024), .LATENCY(15)) u_l15 (
    .clk        (clk),
    .reset      (side_reset),
    .req_valid  (1'b1),
    .req_ready  (s15_ready),
    .req_write  (1'b0),
    .req_addr   (32'h40),
    .req_wdata  (32'h0),
    .resp_valid (s15_valid),
    .resp_ready (1'b1),
    .resp_rdata (s15_rdata),
    .resp_err   (s15_err)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Model: one outstanding transaction, expected response fixed at acceptance.
  logic [31:0] mem_m [NW];
  bit          busy = 1'b0;
  bit          checking = 1'b0;
  int          acc_cyc = 0;
  logic [31:0] exp_rdata;
  logic        exp_err;
  logic        obs_valid, obs_err;
  logic [31:0] obs_rdata;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic bit model_err(input logic [31:0] a);
    return (a % 4 != 0) || (a >= 4 * NW);
  endfunction

  function automatic bit model_valid();
    return busy && (cyc + 1 >= acc_cyc + LAT);
  endfunction

  task automatic tick_check();
    bit ev;
    @(negedge clk);
    obs_valid = resp_valid;
    obs_rdata = resp_rdata;
    obs_err   = resp_err;
    if (checking) begin
      ev = model_valid();
      chk("req_ready", 32'(req_ready), 32'(!busy));
      chk("resp_valid", 32'(resp_valid), 32'(ev));
      if (ev) begin
        chk("resp_rdata", resp_rdata, exp_rdata);
        chk("resp_err", 32'(resp_err), 32'(exp_err));
      end
    end
  endtask

  task automatic tick_drive(input logic rst, v, w, input logic [31:0] a, d, input logic rr);
    reset = rst; req_valid = v; req_write = w; req_addr = a; req_wdata = d; resp_ready = rr;
    if (!rst) begin
      busy = 1'b0;
      foreach (mem_m[i]) mem_m[i] = '0;
      checking = 1'b1;
    end else if (busy) begin
      if (model_valid() && rr) busy = 1'b0;
    end else if (v) begin
      busy      = 1'b1;
      acc_cyc   = cyc + 1;
      exp_err   = model_err(a);
      exp_rdata = '0;
      if (!exp_err) begin
        if (w) mem_m[a / 4] = d;
        else   exp_rdata = mem_m[a / 4];
      end
    end
    @(posedge clk);
    cyc++;
  endtask

  // Issues one request from idle; holds resp_ready low for the first `hold` valid cycles.
  task automatic xact(input logic w, input logic [31:0] a, d, input int hold,
                      output logic [31:0] rd, output logic er, output int lat);
    int seen, n;
    seen = 0; n = 0; rd = 'x; er = 1'bx; lat = -1;
    tick_check();
    tick_drive(1'b1, 1'b1, w, a, d, 1'b1);
    while (busy && n < 64) begin
      tick_check();
      if (obs_valid) begin
        if (seen == 0) lat = cyc + 1 - acc_cyc;
        seen++;
        rd = obs_rdata;
        er = obs_err;
      end
      tick_drive(1'b1, 1'b0, 1'($urandom), $urandom, $urandom, 1'(seen > hold));
      n++;
    end
    chk("xact_completed", 32'(n < 64), 32'd1);
  endtask

  initial begin
    int c, last1, last15, n1, n15;
    side_reset = 1'b0;
    repeat (2) @(negedge clk);
    side_reset = 1'b1;
    c = 0; n1 = 0; n15 = 0; last1 = 0; last15 = 0;
    while ((n1 < 9 || n15 < 9) && c < 400) begin
      @(negedge clk);
      c++;
      if (s1_ready && n1 < 9) begin
        if (n1 > 0) chk("interval_l1", 32'(c - last1), 32'd2);
        last1 = c; n1++;
      end
      if (s15_ready && n15 < 9) begin
        if (n15 > 0) chk("interval_l15", 32'(c - last15), 32'd16);
        last15 = c; n15++;
      end
    end
    chk("side_accepts", 32'(n1 >= 9 && n15 >= 9), 32'd1);
    side_done = 1'b1;
  end

  initial begin
    logic [31:0] rd;
    logic        er;
    int          lat, w;
    logic [31:0] a;
    int          sel;

    // Reset and idle state
    tick_check();
    tick_drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    tick_check();
    tick_drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    tick_check();
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_resp_err", 32'(resp_err), 32'd0);
    chk("rst_resp_rdata", resp_rdata, 32'h0);
    tick_drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
    xact(1'b0, 32'h40, 32'h0, 0, rd, er, lat);
    chk("load40_rdata", rd, 32'h0);

    // Store then load back, latency pinned
    xact(1'b1, 32'h100, 32'hDEADBEEF, 0, rd, er, lat);
    chk("store100_err", 32'(er), 32'd0);
    chk("store100_rdata", rd, 32'h0);
    chk("store_latency", 32'(lat), 32'(LAT));
    xact(1'b0, 32'h100, 32'h0, 0, rd, er, lat);
    chk("load100_rdata", rd, 32'hDEADBEEF);
    chk("load_latency", 32'(lat), 32'(LAT));

    // Error cases; out-of-range store must not alias onto word 0
    xact(1'b0, 32'h102, 32'h0, 0, rd, er, lat);
    chk("misaligned_err", 32'(er), 32'd1);
    chk("misaligned_rdata", rd, 32'h0);
    xact(1'b1, 32'h10000, 32'h12345678, 0, rd, er, lat);
    chk("oor_store_err", 32'(er), 32'd1);
    xact(1'b0, 32'h10000, 32'h0, 0, rd, er, lat);
    chk("oor_load_err", 32'(er), 32'd1);
    chk("oor_load_rdata", rd, 32'h0);
    xact(1'b0, 32'h0, 32'h0, 0, rd, er, lat);
    chk("word0_untouched", rd, 32'h0);
    xact(1'b0, 32'hFFFC, 32'h0, 0, rd, er, lat);
    chk("last_word_err", 32'(er), 32'd0);

    // Response backpressure
    xact(1'b0, 32'h100, 32'h0, 5, rd, er, lat);
    chk("held_rdata", rd, 32'hDEADBEEF);

    // Reset while a load is waiting
    tick_check();
    tick_drive(1'b1, 1'b1, 1'b0, 32'h100, 32'h0, 1'b1);
    tick_check();
    tick_drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
    tick_check();
    chk("abort_resp_valid", 32'(resp_valid), 32'd0);
    chk("abort_req_ready", 32'(req_ready), 32'd1);
    for (int i = 0; i < 6; i++) begin
      tick_drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'($urandom));
      tick_check();
    end
    tick_drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
    xact(1'b0, 32'h100, 32'h0, 0, rd, er, lat);
    chk("cleared_after_reset", rd, 32'h0);

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      tick_check();
      sel = int'($urandom_range(0, 9));
      w   = int'($urandom_range(0, 7));
      if (sel == 0)      a = 32'h100 + 32'($urandom_range(1, 3));
      else if (sel == 1) a = 32'h10000 + 32'(4 * $urandom_range(0, 3));
      else if (sel == 2) a = 32'hFFFC;
      else               a = 32'h100 + 32'(4 * $urandom_range(0, 7));
      tick_drive(1'($urandom_range(0, 99) != 0), 1'($urandom), 1'(w < 4), a, $urandom,
                 1'($urandom_range(0, 3) != 0));
    end

    w = 0;
    while (!side_done && w < 1000) begin
      @(negedge clk);
      w++;
    end
    chk("side_finished", 32'(side_done), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
